// File: rtl/clk_div_checker.sv
// clk_div_checker: measures period and high time of a divided clock or frame
// pulse in clk cycles, checks both against programmed expectations within a
// tolerance and reports lock, per-measurement errors and a sticky timeout.
module clk_div_checker #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_CNT    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [CNT_W-1:0] exp_high,
  input  logic [3:0]       tol,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             period_err,
  output logic             high_err,
  output logic             lock,
  output logic             timeout
);

  localparam int unsigned DIFF_W = CNT_W + 1;
  localparam int unsigned GC_W   = 4;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [GC_W-1:0]  LOCK_TGT = GC_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_s;
  logic                   rise;
  logic                   fall;

  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q,  hi_cnt_d;
  logic [GC_W-1:0]  good_q,    good_d;

  logic [CNT_W-1:0] period_d;
  logic [CNT_W-1:0] high_time_d;
  logic             meas_valid_d;
  logic             period_err_d;
  logic             high_err_d;
  logic             lock_d;
  logic             timeout_d;

  logic [CNT_W-1:0] per_inc;
  logic [CNT_W-1:0] hi_inc;
  logic [GC_W-1:0]  good_inc;
  logic             perr_c;
  logic             herr_c;

  // |meas - expv| > t, evaluated one bit wider so the subtraction cannot wrap
  function automatic logic out_of_tol(input logic [CNT_W-1:0] meas,
                                      input logic [CNT_W-1:0] expv,
                                      input logic [3:0]       t);
    logic [DIFF_W-1:0] a;
    logic [DIFF_W-1:0] b;
    logic [DIFF_W-1:0] d;
    a = {1'b0, meas};
    b = {1'b0, expv};
    d = (a >= b) ? (a - b) : (b - a);
    return (d > DIFF_W'(t));
  endfunction

  // Synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_s;
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign rise   = sync_s & ~prev_q;
  assign fall   = ~sync_s & prev_q;

  // Saturating increments and tolerance checks on the values about to be latched
  assign per_inc  = (per_cnt_q == CNT_MAX) ? per_cnt_q : (per_cnt_q + CNT_ONE);
  assign hi_inc   = (hi_cnt_q == CNT_MAX) ? hi_cnt_q : (hi_cnt_q + CNT_ONE);
  assign good_inc = (good_q >= LOCK_TGT) ? LOCK_TGT : (good_q + GC_W'(1));
  assign perr_c   = out_of_tol(per_cnt_q, exp_period, tol);
  assign herr_c   = out_of_tol(hi_cnt_q, exp_high, tol);

  // State, counters and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      per_cnt_q  <= '0;
      hi_cnt_q   <= '0;
      good_q     <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      period_err <= 1'b0;
      high_err   <= 1'b0;
      lock       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_cnt_q  <= per_cnt_d;
      hi_cnt_q   <= hi_cnt_d;
      good_q     <= good_d;
      period     <= period_d;
      high_time  <= high_time_d;
      meas_valid <= meas_valid_d;
      period_err <= period_err_d;
      high_err   <= high_err_d;
      lock       <= lock_d;
      timeout    <= timeout_d;
    end
  end

  // Next-state, counter and output update; en low overrides every edge event
  always_comb begin
    state_d      = state_q;
    per_cnt_d    = per_cnt_q;
    hi_cnt_d     = hi_cnt_q;
    good_d       = good_q;
    period_d     = period;
    high_time_d  = high_time;
    meas_valid_d = 1'b0;
    period_err_d = period_err;
    high_err_d   = high_err;
    lock_d       = lock;
    timeout_d    = timeout;

    if (!en) begin
      state_d   = IDLE;
      lock_d    = 1'b0;
      timeout_d = 1'b0;
      good_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          lock_d    = 1'b0;
          timeout_d = 1'b0;
          good_d    = '0;
          state_d   = WAIT_EDGE;
        end

        WAIT_EDGE: begin
          if (rise) begin
            per_cnt_d = CNT_ONE;
            hi_cnt_d  = CNT_ONE;
            state_d   = MEAS_HIGH;
          end
        end

        MEAS_HIGH, MEAS_LOW: begin
          if (rise) begin
            // A rise while still high is a glitch and closes the measurement too
            period_d     = per_cnt_q;
            high_time_d  = hi_cnt_q;
            period_err_d = perr_c;
            high_err_d   = herr_c;
            meas_valid_d = 1'b1;
            if (perr_c || herr_c) begin
              good_d = '0;
              lock_d = 1'b0;
            end else begin
              good_d = good_inc;
              lock_d = (good_inc == LOCK_TGT);
            end
            per_cnt_d = CNT_ONE;
            hi_cnt_d  = CNT_ONE;
            state_d   = MEAS_HIGH;
          end else if (per_cnt_q == CNT_MAX) begin
            // Divider looks stuck: drop the measurement and re-arm on next rise
            timeout_d = 1'b1;
            lock_d    = 1'b0;
            good_d    = '0;
            state_d   = WAIT_EDGE;
          end else begin
            per_cnt_d = per_inc;
            if (state_q == MEAS_HIGH) begin
              if (fall) begin
                state_d = MEAS_LOW;
              end else begin
                hi_cnt_d = hi_inc;
              end
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_checker.sv
// Bench for clk_div_checker: table of waveform/expectation vectors feeding a
// scoreboard of expected measurements, plus hand sequences for timeout,
// en-vs-edge collision and asynchronous reset.
module tb_clk_div_checker;

  localparam int LOCK_CNT = 4;
  localparam int NVEC     = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       sig_in = 1'b0;
  logic [7:0] exp_period = 8'd0;
  logic [7:0] exp_high = 8'd0;
  logic [3:0] tol = 4'd0;
  logic [7:0] period;
  logic [7:0] high_time;
  logic       meas_valid;
  logic       period_err;
  logic       high_err;
  logic       lock;
  logic       timeout;

  always #5 clk = ~clk;

  clk_div_checker #(.CNT_W(8), .SYNC_STAGES(2), .LOCK_CNT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sig_in     (sig_in),
    .exp_period (exp_period),
    .exp_high   (exp_high),
    .tol        (tol),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .period_err (period_err),
    .high_err   (high_err),
    .lock       (lock),
    .timeout    (timeout)
  );

  // Waveform shape, expectations, and the result expected for its own periods
  typedef struct {
    int hi;
    int lo;
    int reps;
    int ep;
    int eh;
    int tl;
    int xp_per;
    int xp_hi;
    bit xp_perr;
    bit xp_herr;
  } vec_t;

  typedef struct {
    int per;
    int hi;
    bit perr;
    bit herr;
    bit lk;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t sb [$];
  exp_t mx;

  int n_checks = 0;
  int n_fail   = 0;
  int gc       = 0;
  bit armed    = 1'b0;
  int prev_vec = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic bit off_tol(input int m, input int e, input int t);
    int d;
    d = (m > e) ? (m - e) : (e - m);
    return d > t;
  endfunction

  // Expected result of the period just completed, judged against vector cur
  task automatic push_meas(input int cur);
    exp_t x;
    x.per = vecs[prev_vec].xp_per;
    x.hi  = vecs[prev_vec].xp_hi;
    if (prev_vec == cur) begin
      x.perr = vecs[cur].xp_perr;
      x.herr = vecs[cur].xp_herr;
    end else begin
      x.perr = off_tol(vecs[prev_vec].xp_per, vecs[cur].ep, vecs[cur].tl);
      x.herr = off_tol(vecs[prev_vec].xp_hi, vecs[cur].eh, vecs[cur].tl);
    end
    if (x.perr || x.herr) gc = 0;
    else if (gc < LOCK_CNT) gc++;
    x.lk = (gc == LOCK_CNT);
    sb.push_back(x);
  endtask

  task automatic drive(input bit v, input int n);
    sig_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic run_vec(input int i);
    exp_period = 8'(vecs[i].ep);
    exp_high   = 8'(vecs[i].eh);
    tol        = 4'(vecs[i].tl);
    for (int r = 0; r < vecs[i].reps; r++) begin
      if (armed) push_meas(i);
      drive(1'b1, vecs[i].hi);
      drive(1'b0, vecs[i].lo);
      armed    = 1'b1;
      prev_vec = i;
    end
  endtask

  task automatic start_meas();
    en = 1'b1;
    drive(1'b0, 4);
  endtask

  // Close the last period with a rise, then disable
  task automatic close_and_stop();
    if (armed) push_meas(prev_vec);
    drive(1'b1, 6);
    en = 1'b0;
    drive(1'b0, 4);
    armed = 1'b0;
    gc    = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_high_time"}, int'(high_time), 0);
    chk({tag, "_meas_valid"}, int'(meas_valid), 0);
    chk({tag, "_period_err"}, int'(period_err), 0);
    chk({tag, "_high_err"}, int'(high_err), 0);
    chk({tag, "_lock"}, int'(lock), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
  endtask

  // Scoreboard: every strobe must match the oldest pending expectation
  always @(posedge clk) begin
    #1;
    if (meas_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: meas_valid=1 with nothing pending, period=%0d high_time=%0d",
                 period, high_time);
      end else begin
        mx = sb.pop_front();
        chk("sb_period", int'(period), mx.per);
        chk("sb_high_time", int'(high_time), mx.hi);
        chk("sb_period_err", int'(period_err), int'(mx.perr));
        chk("sb_high_err", int'(high_err), int'(mx.herr));
        chk("sb_lock", int'(lock), int'(mx.lk));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int w;
    //           hi lo reps ep eh tl  per hi perr herr
    vecs[0] = '{8,  8,  6, 16, 8, 0, 16, 8, 1'b0, 1'b0};
    vecs[1] = '{8,  8,  3, 18, 8, 2, 16, 8, 1'b0, 1'b0};
    vecs[2] = '{8,  8,  1, 18, 8, 1, 16, 8, 1'b1, 1'b0};
    vecs[3] = '{8,  8,  6, 16, 8, 0, 16, 8, 1'b0, 1'b0};
    vecs[4] = '{4, 28,  4, 32, 4, 0, 32, 4, 1'b0, 1'b0};
    vecs[5] = '{3, 29,  3, 32, 4, 0, 32, 3, 1'b0, 1'b1};

    // Reset, then idle with en low while sig_in toggles
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 2);
      drive(1'b0, 2);
    end
    chk_zero("idle");

    // Table: square waves, tolerance boundary, relock, short frame pulses
    start_meas();
    for (int i = 0; i < NVEC; i++) run_vec(i);
    close_and_stop();
    chk("hold_period", int'(period), 32);
    chk("hold_high_time", int'(high_time), 3);
    chk("hold_high_err", int'(high_err), 1);
    chk("en_off_lock", int'(lock), 0);

    // Stuck divider after lock
    start_meas();
    run_vec(0);
    chk("pre_stuck_lock", int'(lock), 1);
    w = 0;
    while (!timeout && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("timeout_set", int'(timeout), 1);
    chk("timeout_lock", int'(lock), 0);
    armed = 1'b0;
    gc    = 0;
    run_vec(0);
    chk("timeout_sticky", int'(timeout), 1);
    chk("relock_after_timeout", int'(lock), 1);
    close_and_stop();
    chk("timeout_cleared", int'(timeout), 0);

    // en falls in the very cycle the rise is detected: no measurement
    start_meas();
    run_vec(0);
    sig_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    drive(1'b1, 5);
    drive(1'b0, 8);
    armed = 1'b0;
    gc    = 0;
    chk("collide_period_held", int'(period), 16);
    chk("collide_high_held", int'(high_time), 8);
    chk("collide_lock", int'(lock), 0);
    chk("collide_pending", sb.size(), 0);

    // Asynchronous reset in the low phase of a measurement
    start_meas();
    run_vec(0);
    drive(1'b0, 3);
    #2 rst = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst   = 1'b1;
    armed = 1'b0;
    gc    = 0;
    drive(1'b0, 4);
    drive(1'b1, 8);
    drive(1'b0, 8);
    chk_zero("post_rst");

    repeat (10) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
